// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stages and their controllers:
// controller state encodings, default datapath widths and a saturating
// width-reduction helper.
package fft_pkg;

  // Controller state codes (2-bit, fully decoded)
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_FIRST   = 2'b01;
  localparam logic [1:0] ST_SECOND  = 2'b10;
  localparam logic [1:0] ST_WAITING = 2'b11;

  // Default datapath widths
  localparam int DW_DEF    = 14;
  localparam int WW_DEF    = 8;
  localparam int WFRAC_DEF = 6;

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Feedback delay line for an SDF stage: a DEPTH-entry circular buffer
// with one shared read/write pointer. The head is the entry written
// DEPTH shifts ago; each shift overwrites it with din and advances.
module sdf_delay_line #(
  parameter int W     = 28,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  assign head = mem[ptr];

  // Write the new sample over the oldest one and advance the pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr <= '0;
    end else if (shift_en) begin
      mem[ptr] <= din;
      ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sdf_bf2_stage8.sv
// Second radix-2 SDF stage of the 32-point FFT (8-deep feedback).
// FIRST emits g = B + A and feeds h = B - A back; SECOND emits the fed-back
// h multiplied by the controller's twiddle WN. Outputs are registered.
// Build option: define SDF_BF2_SAT_EN to saturate butterfly and multiplier
// results to DW bits; otherwise they wrap (two's complement truncation).
module sdf_bf2_stage8
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int WW    = WW_DEF,
  parameter int WFRAC = WFRAC_DEF,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic [1:0]           state_i,
  input  logic signed [DW-1:0] a_r_i,
  input  logic signed [DW-1:0] a_i_i,
  input  logic signed [WW-1:0] wn_r_i,
  input  logic signed [WW-1:0] wn_i_i,
  output logic                 valid_o,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i
);

  localparam int PW = DW + WW + 1;

  // Reduce a wide signed result to DW bits (saturate or wrap).
  function automatic logic signed [DW-1:0] reduce(input logic signed [31:0] v);
`ifdef SDF_BF2_SAT_EN
    logic signed [31:0] s;
    s = saturate(v, DW);
    return s[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction

  // Round a Q(WFRAC) product half toward +inf, then reduce to DW bits.
  function automatic logic signed [DW-1:0] round_q(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = (p + PW'(1 <<< (WFRAC - 1))) >>> WFRAC;
    return reduce(32'(t));
  endfunction

  logic [2*DW-1:0]      head;
  logic [2*DW-1:0]      din;
  logic                 shift_en;
  logic signed [DW-1:0] b_r, b_i;
  logic signed [DW:0]   sum_r, sum_i, dif_r, dif_i;
  logic signed [PW-1:0] prod_r, prod_i;
  logic signed [DW-1:0] push_r, push_i;
  logic signed [DW-1:0] nxt_r, nxt_i;
  logic signed [DW-1:0] out_r_p1, out_i_p1;
  logic                 vld_p1;

  sdf_delay_line #(
    .W     (2 * DW),
    .DEPTH (DEPTH)
  ) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (din),
    .head     (head)
  );

  assign b_r = head[2*DW-1:DW];
  assign b_i = head[DW-1:0];
  assign din = {push_r, push_i};

  // Butterfly and complex multiply on the delay-line head
  always_comb begin
    sum_r  = (DW+1)'(b_r) + (DW+1)'(a_r_i);
    sum_i  = (DW+1)'(b_i) + (DW+1)'(a_i_i);
    dif_r  = (DW+1)'(b_r) - (DW+1)'(a_r_i);
    dif_i  = (DW+1)'(b_i) - (DW+1)'(a_i_i);
    prod_r = PW'(b_r) * PW'(wn_r_i) - PW'(b_i) * PW'(wn_i_i);
    prod_i = PW'(b_r) * PW'(wn_i_i) + PW'(b_i) * PW'(wn_r_i);
  end

  // Select next output and delay-line feed from the controller state
  always_comb begin
    shift_en = 1'b0;
    push_r   = a_r_i;
    push_i   = a_i_i;
    nxt_r    = '0;
    nxt_i    = '0;
    case (state_i)
      ST_IDLE: begin
      end
      ST_WAITING: begin
        shift_en = 1'b1;
      end
      ST_FIRST: begin
        shift_en = 1'b1;
        nxt_r    = reduce(32'(sum_r));
        nxt_i    = reduce(32'(sum_i));
        push_r   = reduce(32'(dif_r));
        push_i   = reduce(32'(dif_i));
      end
      ST_SECOND: begin
        shift_en = 1'b1;
        nxt_r    = round_q(prod_r);
        nxt_i    = round_q(prod_i);
      end
      default: begin
      end
    endcase
  end

  // p0 -> p1: register output sample and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      out_r_p1 <= '0;
      out_i_p1 <= '0;
    end else begin
      vld_p1   <= valid_i;
      out_r_p1 <= nxt_r;
      out_i_p1 <= nxt_i;
    end
  end

  assign valid_o = vld_p1;
  assign dout_r  = out_r_p1;
  assign dout_i  = out_i_p1;

endmodule

// File: tb/tb_sdf_bf2_stage8.sv
// Bench for sdf_bf2_stage8: frame-level FFT-stage model (g = x[n]+x[n+8],
// out = round((x[k]-x[k+8]) * W[k])) feeding an expectation queue that a
// single compare process checks every cycle.
module tb_sdf_bf2_stage8;
  localparam int DW = 14;
  localparam int WW = 8;
  localparam int MAXV = 8191;
  localparam int MINV = -8192;
  localparam logic [1:0] S_IDLE = 2'b00, S_FIRST = 2'b01, S_SECOND = 2'b10, S_WAIT = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_i = 1'b0;
  logic [1:0] state_i = S_IDLE;
  logic signed [DW-1:0] a_r_i = '0, a_i_i = '0;
  logic signed [WW-1:0] wn_r_i = '0, wn_i_i = '0;
  logic valid_o;
  logic signed [DW-1:0] dout_r, dout_i;

  always #5 clk = ~clk;

  sdf_bf2_stage8 dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .state_i(state_i),
    .a_r_i(a_r_i), .a_i_i(a_i_i), .wn_r_i(wn_r_i), .wn_i_i(wn_i_i),
    .valid_o(valid_o), .dout_r(dout_r), .dout_i(dout_i)
  );

  typedef struct { bit v; int r; int i; } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int vcount = 0, vrun = 0, vrun_max = 0;
  int xr[4][16], xi[4][16];
  int wr[8], wi[8];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: reduce to DW bits, per build option
  function automatic int red(input int v);
`ifdef SDF_BF2_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
`else
    return ((v + 8192) & 16383) - 8192;
`endif
  endfunction

  function automatic int cm_r(input int br, bi, w_r, w_i);
    return red((br * w_r - bi * w_i + 32) >>> 6);
  endfunction

  function automatic int cm_i(input int br, bi, w_r, w_i);
    return red((br * w_i + bi * w_r + 32) >>> 6);
  endfunction

  task automatic set_w16();
    wr = '{64, 59, 45, 24, 0, -24, -45, -59};
    wi = '{0, -24, -45, -59, -64, -59, -45, -24};
  endtask

  // Drive one cycle of inputs and queue the output expected one cycle later
  task automatic drive(input logic [1:0] st, input bit v, input int ar, ai,
                       input int w_r, w_i, input bit ev, input int er, ei);
    exp_t e;
    @(negedge clk);
    state_i = st; valid_i = v;
    a_r_i = DW'(ar); a_i_i = DW'(ai);
    wn_r_i = WW'(w_r); wn_i_i = WW'(w_i);
    if (!rst_n) e = '{1'b0, 0, 0};
    else e = '{ev, er, ei};
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++)
      drive(S_IDLE, 0, $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
            $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 0, 0, 0);
  endtask

  // Stream nf back-to-back frames from xr/xi; optional IDLE gap after fill
  task automatic run_frames(input int nf, input int gap);
    for (int n = 0; n < 8; n++) drive(S_WAIT, 0, xr[0][n], xi[0][n], 0, 0, 0, 0, 0);
    idle(gap);
    for (int f = 0; f < nf; f++) begin
      for (int n = 0; n < 8; n++)
        drive(S_FIRST, 1, xr[f][n+8], xi[f][n+8], 0, 0, 1,
              red(xr[f][n] + xr[f][n+8]), red(xi[f][n] + xi[f][n+8]));
      for (int k = 0; k < 8; k++) begin
        int hr, hi, nr, ni;
        hr = red(xr[f][k] - xr[f][k+8]);
        hi = red(xi[f][k] - xi[f][k+8]);
        nr = (f + 1 < nf) ? xr[f+1][k] : 0;
        ni = (f + 1 < nf) ? xi[f+1][k] : 0;
        drive(S_SECOND, 1, nr, ni, wr[k], wi[k], 1, cm_r(hr, hi, wr[k], wi[k]), cm_i(hr, hi, wr[k], wi[k]));
      end
    end
    idle(3);
  endtask

  // Compare process: one expectation per cycle, sampled after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        vcount++; vrun++;
        if (vrun > vrun_max) vrun_max = vrun;
      end else vrun = 0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_o", int'(valid_o), e.v ? 1 : 0);
        check("dout_r", int'(dout_r), e.r);
        check("dout_i", int'(dout_i), e.i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    set_w16();

    // Model pins (hand-computed)
    check("pin_g0", red(0 + 8), 8);
    check("pin_g7", red(7 + 15), 22);
    check("pin_h0_r", cm_r(-8, 0, 64, 0), -8);
    check("pin_h4_r", cm_r(-8, 0, 0, -64), 0);
    check("pin_h4_i", cm_i(-8, 0, 0, -64), 8);
`ifdef SDF_BF2_SAT_EN
    check("pin_sat", red(16382), 8191);
`else
    check("pin_wrap", red(16382), -2);
`endif
    check("pin_rnd1_r", cm_r(1, 0, 59, -25), 1);
    check("pin_rnd1_i", cm_i(1, 0, 59, -25), 0);
    check("pin_rnd2_r", cm_r(-1, 0, 32, 0), 0);
    check("pin_rnd3_r", cm_r(-1, 0, 33, 0), -1);

    // 1: reset with random inputs, then IDLE
    for (int c = 0; c < 4; c++)
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 16383) - 8192,
            $urandom_range(0, 16383) - 8192, 50, -50, 1, 1, 1);
    @(posedge clk); #3 rst_n = 1'b1;
    idle(8);

    // 2: ramp frame, with an IDLE gap after fill that must not shift
    for (int n = 0; n < 16; n++) begin xr[0][n] = n; xi[0][n] = 0; end
    v0 = vcount; vrun_max = 0;
    run_frames(1, 3);
    check("t2_valid_cycles", vcount - v0, 16);
    check("t2_valid_run", vrun_max, 16);

    // 3: four back-to-back full-range random frames
    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 16; n++) begin
        xr[f][n] = $urandom_range(0, 16383) - 8192;
        xi[f][n] = $urandom_range(0, 16383) - 8192;
      end
    v0 = vcount; vrun_max = 0;
    run_frames(4, 0);
    check("t3_valid_cycles", vcount - v0, 64);
    check("t3_valid_run", vrun_max, 64);

    // 4: x[n] = x[n+8] = 8191
    for (int n = 0; n < 16; n++) begin xr[0][n] = MAXV; xi[0][n] = 0; end
    run_frames(1, 0);

    // 5: rounding with h = +1 and h = -1
    for (int n = 0; n < 16; n++) begin xr[0][n] = 0; xi[0][n] = 0; end
    xr[0][1] = 1; xr[0][2] = -1;
    wr[1] = 59; wi[1] = -25; wr[2] = 32; wi[2] = 0;
    run_frames(1, 0);
    set_w16();

    // 6: reset during FIRST cycle 3, then a fresh frame of ones
    for (int n = 0; n < 8; n++) drive(S_WAIT, 0, 100 + n, -n, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++)
      drive(S_FIRST, 1, 300, 7, 0, 0, 1, red(100 + n + 300), red(-n + 7));
    @(posedge clk); #3 rst_n = 1'b0;
    drive(S_FIRST, 1, 300, 7, 0, 0, 1, 1, 1);
    drive(S_FIRST, 1, 300, 7, 0, 0, 1, 1, 1);
    @(posedge clk); #3 rst_n = 1'b1;
    idle(2);
    for (int n = 0; n < 16; n++) begin xr[0][n] = 1; xi[0][n] = 0; end
    run_frames(1, 0);

    @(posedge clk); #2;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
